// File: rtl/uart_frame_if.sv
// uart_frame_if: rx byte strobe in, register-bank write port and status out.
// Ports: rx_valid/rx_data/rx_err to ctrl; wr_en/wr_addr/wr_data, busy, frame_ok/err, err_code, overrun from ctrl.
interface uart_frame_if #(
  parameter int ADDR_W = 2
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              frame_ok;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              overrun;

  modport master (
    output rx_valid, rx_data, rx_err,
    input  wr_en, wr_addr, wr_data,
    input  busy, frame_ok, frame_err,
    input  err_code, overrun
  );

  modport slave (
    input  rx_valid, rx_data, rx_err,
    output wr_en, wr_addr, wr_data,
    output busy, frame_ok, frame_err,
    output err_code, overrun
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: frames rx bytes (SOF ADDR LEN DATA.. CSUM), commits on good xor csum.
// Ports: clk, rst (async high), bus (uart_frame_if.slave: rx strobe in, reg writes/status out).
module uart_frame_ctrl #(
  parameter logic [7:0] SOF         = 8'hA5,
  parameter int         MAX_LEN     = 4,
  parameter int         ADDR_W      = 2,
  parameter int         TIMEOUT_CYC = 3000
) (
  input logic          clk,
  input logic          rst,
  uart_frame_if.slave  bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] MAXB = 8'(MAX_LEN);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_COMMIT
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     idx_q;
  logic [7:0]        csum_q;
  logic [TW-1:0]     tmo_q;
  logic [7:0]        buf_q [2**IW];

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              busy_q;
  logic              frame_ok_q;
  logic              frame_err_q;
  logic [1:0]        err_q;
  logic              overrun_q;

  logic [7:0]        csum_d;
  logic [LW-1:0]     idx_d;
  logic              tmo_hit_d;

  assign csum_d    = csum_q ^ bus.rx_data;
  assign idx_d     = idx_q + LW'(1);
  assign tmo_hit_d = (tmo_q == TLAST);

  // Payload store; contents are don't-care until written in DATA.
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && bus.rx_valid && !bus.rx_err)
      buf_q[idx_q[IW-1:0]] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_q       <= 2'd0;
      overrun_q   <= 1'b0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.rx_valid && bus.rx_data == SOF) begin
            state_q <= S_ADDR;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
          end
        end
        S_ADDR, S_LEN, S_DATA, S_CSUM: begin
          tmo_q <= bus.rx_valid ? '0 : tmo_q + TW'(1);
          // rx_err beats a same-cycle byte; a byte beats timeout.
          if (bus.rx_err || (!bus.rx_valid && tmo_hit_d)) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            err_q       <= 2'd3;
          end else if (bus.rx_valid) begin
            unique case (state_q)
              S_ADDR: begin
                base_q  <= bus.rx_data[ADDR_W-1:0];
                csum_q  <= bus.rx_data;
                state_q <= S_LEN;
              end
              S_LEN: begin
                csum_q <= csum_d;
                if (bus.rx_data != 8'd0 && bus.rx_data <= MAXB) begin
                  len_q   <= bus.rx_data[LW-1:0];
                  idx_q   <= '0;
                  state_q <= S_DATA;
                end else begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  frame_err_q <= 1'b1;
                  err_q       <= 2'd2;
                end
              end
              S_DATA: begin
                csum_q <= csum_d;
                idx_q  <= idx_d;
                if (idx_d == len_q)
                  state_q <= S_CSUM;
              end
              S_CSUM: begin
                if (bus.rx_data == csum_q) begin
                  // First write issues straight away; idx tracks the next one.
                  state_q   <= S_COMMIT;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= base_q;
                  wr_data_q <= buf_q[0];
                  idx_q     <= LW'(1);
                end else begin
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
                  frame_err_q <= 1'b1;
                  err_q       <= 2'd1;
                end
              end
              default: ;
            endcase
          end
        end
        S_COMMIT: begin
          overrun_q <= bus.rx_valid;
          if (idx_q == len_q) begin
            wr_en_q    <= 1'b0;
            frame_ok_q <= 1'b1;
            err_q      <= 2'd0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            wr_addr_q <= base_q + ADDR_W'(idx_q);
            wr_data_q <= buf_q[idx_q[IW-1:0]];
            idx_q     <= idx_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed frames against uart_frame_ctrl.
// Drives bytes on negedge, samples outputs on negedge.
module tb_uart_frame_ctrl;

  localparam int TMO = 3000;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   wr_cnt;
  int   ok_cnt;
  int   w0;
  int   f0;

  uart_frame_if #(.ADDR_W(2)) bus ();

  uart_frame_ctrl #(
    .SOF(8'hA5),
    .MAX_LEN(4),
    .ADDR_W(2),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.wr_en)    wr_cnt <= wr_cnt + 1;
    if (bus.frame_ok) ok_cnt <= ok_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic expw(input string tag, input logic [1:0] a,
                      input logic [7:0] d);
    chk({tag, ".wr_en"}, bus.wr_en, 1'b1);
    chk({tag, ".addr"}, bus.wr_addr, a);
    chk({tag, ".data"}, bus.wr_data, d);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    wr_cnt = 0;
    ok_cnt = 0;
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_err   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.wr_en", bus.wr_en, 1'b0);
    chk("rst.addr", bus.wr_addr, 2'd0);
    chk("rst.data", bus.wr_data, 8'h00);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.ok", bus.frame_ok, 1'b0);
    chk("rst.err", bus.frame_err, 1'b0);
    chk("rst.code", bus.err_code, 2'd0);
    chk("rst.ovr", bus.overrun, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // non-SOF byte in IDLE is ignored
    send(8'h11);
    chk("idle.busy", bus.busy, 1'b0);
    chk("idle.err", bus.frame_err, 1'b0);

    // good frame
    send(8'hA5); send(8'h01);
    chk("good.busy_in", bus.busy, 1'b1);
    send(8'h02); send(8'h11); send(8'h22); send(8'h30);
    expw("good.w0", 2'd1, 8'h11);
    chk("good.busy_c", bus.busy, 1'b1);
    @(negedge clk);
    expw("good.w1", 2'd2, 8'h22);
    @(negedge clk);
    chk("good.ok", bus.frame_ok, 1'b1);
    chk("good.wr_off", bus.wr_en, 1'b0);
    chk("good.busy", bus.busy, 1'b0);
    chk("good.addr_hold", bus.wr_addr, 2'd2);
    chk("good.data_hold", bus.wr_data, 8'h22);
    @(negedge clk);
    chk("good.ok_pulse", bus.frame_ok, 1'b0);

    // address wrap
    send(8'hA5); send(8'h03); send(8'h02);
    send(8'hAA); send(8'hBB); send(8'h10);
    expw("wrap.w0", 2'd3, 8'hAA);
    @(negedge clk);
    expw("wrap.w1", 2'd0, 8'hBB);
    @(negedge clk);
    chk("wrap.ok", bus.frame_ok, 1'b1);
    chk("wrap.code", bus.err_code, 2'd0);

    // bad checksum, then good one clears err_code
    w0 = wr_cnt;
    send(8'hA5); send(8'h00); send(8'h01); send(8'h55); send(8'h00);
    chk("csum.err", bus.frame_err, 1'b1);
    chk("csum.code", bus.err_code, 2'd1);
    chk("csum.busy", bus.busy, 1'b0);
    chk("csum.wr_en", bus.wr_en, 1'b0);
    @(negedge clk);
    chk("csum.err_pulse", bus.frame_err, 1'b0);
    chk("csum.code_hold", bus.err_code, 2'd1);
    chk("csum.nowr", wr_cnt, w0);
    send(8'hA5); send(8'h00); send(8'h01); send(8'h55); send(8'h54);
    expw("csum2.w0", 2'd0, 8'h55);
    @(negedge clk);
    chk("csum2.ok", bus.frame_ok, 1'b1);
    chk("csum2.code", bus.err_code, 2'd0);

    // bad length, then a new frame starts cleanly
    send(8'hA5); send(8'h00); send(8'h05);
    chk("len5.err", bus.frame_err, 1'b1);
    chk("len5.code", bus.err_code, 2'd2);
    chk("len5.busy", bus.busy, 1'b0);
    send(8'hA5); send(8'h01); send(8'h01); send(8'h77); send(8'h77);
    expw("len5b.w0", 2'd1, 8'h77);
    @(negedge clk);
    chk("len5b.ok", bus.frame_ok, 1'b1);
    send(8'hA5); send(8'h00); send(8'h00);
    chk("len0.err", bus.frame_err, 1'b1);
    chk("len0.code", bus.err_code, 2'd2);

    // timeout after ADDR
    send(8'hA5); send(8'h02);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo.early_err", bus.frame_err, 1'b0);
    chk("tmo.early_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("tmo.err", bus.frame_err, 1'b1);
    chk("tmo.code", bus.err_code, 2'd3);
    chk("tmo.busy", bus.busy, 1'b0);

    // MAX_LEN frame with a byte injected during COMMIT
    send(8'hA5); send(8'h02); send(8'h04);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h02);
    expw("ovr.w0", 2'd2, 8'h01);
    chk("ovr.none", bus.overrun, 1'b0);
    send(8'hA5);
    chk("ovr.pulse", bus.overrun, 1'b1);
    expw("ovr.w1", 2'd3, 8'h02);
    @(negedge clk);
    chk("ovr.pulse_end", bus.overrun, 1'b0);
    expw("ovr.w2", 2'd0, 8'h03);
    @(negedge clk);
    expw("ovr.w3", 2'd1, 8'h04);
    @(negedge clk);
    chk("ovr.ok", bus.frame_ok, 1'b1);
    chk("ovr.busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("ovr.dropped", bus.busy, 1'b0);

    // rx_err with a DATA byte
    w0 = wr_cnt;
    send(8'hA5); send(8'h00); send(8'h02); send(8'h11);
    bus.rx_err = 1'b1;
    send(8'h22);
    bus.rx_err = 1'b0;
    chk("rxe.err", bus.frame_err, 1'b1);
    chk("rxe.code", bus.err_code, 2'd3);
    chk("rxe.busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("rxe.nowr", wr_cnt, w0);
    chk("rxe.idle", bus.busy, 1'b0);

    // reset during COMMIT
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h10); send(8'h20); send(8'h32);
    expw("rstc.w0", 2'd0, 8'h10);
    w0 = wr_cnt;
    f0 = ok_cnt;
    #1 rst = 1'b1;
    #1;
    chk("rstc.wr_en", bus.wr_en, 1'b0);
    chk("rstc.busy", bus.busy, 1'b0);
    chk("rstc.code", bus.err_code, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstc.nowr", wr_cnt, w0);
    chk("rstc.nook", ok_cnt, f0);
    chk("rstc.idle", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
